// File: rtl/ysyx_22050078_wbu.sv
// ---------------------------------------------------------------------------
// ysyx_22050078_wbu -- writeback unit feeding the 32x64 integer register file
//
// The unit merges two result sources onto the register file's single write
// port. The sources are the execute unit (EXU) and the load path (LSU).
//
// Load responses cannot be back-pressured. They always win the write port.
// An EXU result that loses arbitration is parked in a one-entry holding
// buffer. While that buffer is full, exu_ready is low.
//
// Load data is lane-selected and then sign- or zero-extended here. Writes to
// x0 are suppressed. A retire counter and a sticky error flag are kept for
// simulation.
//
// Ports
//   clk, rst         clock; synchronous active-high reset
//   exu_valid/ready  EXU result handshake (ready depends only on buffer state)
//   exu_wen          EXU instruction writes rd
//   exu_rd           EXU destination register
//   exu_data         EXU result
//   lsu_valid        load response valid, consumed every cycle it is high
//   lsu_rd           load destination register
//   lsu_funct3       load type
//   lsu_addr_lo      load address bits [2:0]
//   lsu_rdata        aligned 8-byte memory word
//   rf_wen           registered regfile write enable
//   rf_waddr         registered regfile write address
//   rf_wdata         registered regfile write data
//   o_retire_cnt     number of committed results (wraps modulo 2^64)
//   o_err            sticky flag: a reserved load funct3 was committed
// ---------------------------------------------------------------------------
module ysyx_22050078_wbu #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  exu_valid,
  output logic                  exu_ready,
  input  logic                  exu_wen,
  input  logic [ADDR_WIDTH-1:0] exu_rd,
  input  logic [DATA_WIDTH-1:0] exu_data,
  input  logic                  lsu_valid,
  input  logic [ADDR_WIDTH-1:0] lsu_rd,
  input  logic [2:0]            lsu_funct3,
  input  logic [2:0]            lsu_addr_lo,
  input  logic [DATA_WIDTH-1:0] lsu_rdata,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic [63:0]           o_retire_cnt,
  output logic                  o_err
);

  localparam logic [2:0] F3_RSVD = 3'b111;

  // Lane select plus extension for a load response.
  //
  // The sub-word lane is picked by the naturally aligned part of the offset.
  // Low offset bits below the access size are ignored, because the LSU is
  // responsible for misalignment traps.
  //
  // funct3[2] selects zero-extension. The reserved code 111 yields zero.
  function automatic logic [DATA_WIDTH-1:0] load_extract(
    input logic [2:0]            f3,
    input logic [2:0]            off,
    input logic [DATA_WIDTH-1:0] word
  );
    logic signed [7:0]     byte_s;
    logic signed [15:0]    half_s;
    logic signed [31:0]    word_s;
    logic [DATA_WIDTH-1:0] res;

    byte_s = word[{off, 3'b000} +: 8];
    half_s = word[{off[2:1], 4'b0000} +: 16];
    word_s = word[{off[2], 5'b00000} +: 32];
    res    = '0;

    case (f3)
      3'b000:  res = {{(DATA_WIDTH-8){byte_s[7]}}, byte_s};
      3'b001:  res = {{(DATA_WIDTH-16){half_s[15]}}, half_s};
      3'b010:  res = {{(DATA_WIDTH-32){word_s[31]}}, word_s};
      3'b011:  res = word;
      3'b100:  res = {{(DATA_WIDTH-8){1'b0}}, byte_s};
      3'b101:  res = {{(DATA_WIDTH-16){1'b0}}, half_s};
      3'b110:  res = {{(DATA_WIDTH-32){1'b0}}, word_s};
      default: res = '0;
    endcase

    return res;
  endfunction

  // Holding buffer for one EXU result
  logic                  buf_valid_q, buf_valid_d;
  logic                  buf_wen_q,   buf_wen_d;
  logic [ADDR_WIDTH-1:0] buf_rd_q,    buf_rd_d;
  logic [DATA_WIDTH-1:0] buf_data_q,  buf_data_d;

  // Registered write port, counters and flags
  logic                  rf_wen_q,    rf_wen_d;
  logic [ADDR_WIDTH-1:0] rf_waddr_q,  rf_waddr_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q,  rf_wdata_d;
  logic [63:0]           retire_q,    retire_d;
  logic                  err_q,       err_d;

  // Commit arbitration
  logic                  exu_hs;
  logic                  sel_lsu;
  logic                  sel_buf;
  logic                  sel_exu;
  logic                  commit;
  logic                  c_wen;
  logic [ADDR_WIDTH-1:0] c_rd;
  logic [DATA_WIDTH-1:0] c_data;

  // Ready is driven from the buffer register alone. This keeps it free of
  // any combinational path from exu_valid.
  assign exu_ready = !buf_valid_q;
  assign exu_hs    = exu_valid && exu_ready;

  always_comb begin
    sel_lsu = lsu_valid;
    sel_buf = !lsu_valid && buf_valid_q;
    sel_exu = !lsu_valid && !buf_valid_q && exu_hs;
    commit  = sel_lsu || sel_buf || sel_exu;

    c_wen  = 1'b0;
    c_rd   = '0;
    c_data = '0;
    if (sel_lsu) begin
      c_wen  = 1'b1;
      c_rd   = lsu_rd;
      c_data = load_extract(lsu_funct3, lsu_addr_lo, lsu_rdata);
    end else if (sel_buf) begin
      c_wen  = buf_wen_q;
      c_rd   = buf_rd_q;
      c_data = buf_data_q;
    end else if (sel_exu) begin
      c_wen  = exu_wen;
      c_rd   = exu_rd;
      c_data = exu_data;
    end

    buf_valid_d = buf_valid_q;
    buf_wen_d   = buf_wen_q;
    buf_rd_d    = buf_rd_q;
    buf_data_d  = buf_data_q;
    if (sel_buf) begin
      buf_valid_d = 1'b0;
    end
    // An accepted EXU result that lost arbitration is parked. This can
    // only happen with the buffer empty, since ready is low while it is full.
    if (exu_hs && !sel_exu) begin
      buf_valid_d = 1'b1;
      buf_wen_d   = exu_wen;
      buf_rd_d    = exu_rd;
      buf_data_d  = exu_data;
    end

    // Commits to x0 still update the address/data registers; only the
    // enable is suppressed.
    rf_wen_d   = commit && c_wen && (c_rd != '0);
    rf_waddr_d = commit ? c_rd   : rf_waddr_q;
    rf_wdata_d = commit ? c_data : rf_wdata_q;

    retire_d = retire_q + {63'd0, commit};
    err_d    = err_q || (sel_lsu && (lsu_funct3 == F3_RSVD));
  end

  // Stage boundary: committed entry -> registered write port
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid_q <= 1'b0;
      rf_wen_q    <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      retire_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      buf_valid_q <= buf_valid_d;
      rf_wen_q    <= rf_wen_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      retire_q    <= retire_d;
      err_q       <= err_d;
    end
  end

  // Buffer payload is qualified by buf_valid_q, so it carries no reset.
  always_ff @(posedge clk) begin
    buf_wen_q  <= buf_wen_d;
    buf_rd_q   <= buf_rd_d;
    buf_data_q <= buf_data_d;
  end

  assign rf_wen       = rf_wen_q;
  assign rf_waddr     = rf_waddr_q;
  assign rf_wdata     = rf_wdata_q;
  assign o_retire_cnt = retire_q;
  assign o_err        = err_q;

endmodule
